bt_cmd_decoder: RTL and testbench

//  Parametrised Bluetooth-UART remote-control front end for the MP3 player.
//  - Receives 8N1 bytes from the BT module and decodes them into one-cycle command pulses
//    (prev/next with step count, volume up/down, absolute track select).
//  - Echoes an acknowledge byte back to the phone on UART_TXD.
//  - Sits between the board UART pins and the player control FSM.
//  - Track count and baud rate are parameters; 8 tracks at 9600 Bd is the fixed build.

---
 rtl/bt_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 92 +++++++++
 rtl/bt_cmd_decoder.sv | 186 ++++++++++++++++++
 tb/tb_bt_cmd_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// Shared opcodes, acknowledge code and UART FSM state encodings for the
// Bluetooth remote-control front end.
package bt_pkg;

  // Command opcodes carried in one received byte
  localparam logic [7:0] CMD_PREV     = 8'h01;
  localparam logic [7:0] CMD_NEXT     = 8'h02;
  localparam logic [7:0] CMD_VUP      = 8'h03;
  localparam logic [7:0] CMD_VDN      = 8'h04;
  localparam logic [7:0] CMD_SEL_BASE = 8'h05;

  // Acknowledge byte for anything that was not a legal command
  localparam logic [7:0] ACK_ERR      = 8'hFF;

  // State encodings used by both the RX and TX serial FSMs
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver driven by an oversampling tick. Emits a one-cycle
// rx_valid with the byte on a good stop bit, or a one-cycle frame_err.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic       rxd_sync,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);
  import bt_pkg::*;

  localparam int             CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(OVERSAMPLE - 1);

  logic [1:0]    state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Receive FSM: mid-bit sampling, returns to IDLE right after the stop sample
  // so a start edge following immediately is caught.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the pulse
      // defaults below are overridden later in the same block when they fire.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxd_sync) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rxd_sync ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shift    <= {rxd_sync, shift[7:1]};
              bit_idx  <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              if (rxd_sync) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bt_cmd_decoder.sv
// Bluetooth-UART remote-control front end: receives command bytes, decodes
// them into one-cycle pulses for the player FSM and echoes an ack byte.
module bt_cmd_decoder #(
  parameter  int CLK_HZ     = 100_000_000,
  parameter  int BAUD       = 9600,
  parameter  int OVERSAMPLE = 16,
  parameter  int NUM_TRACKS = 8,
  parameter  int ECHO_EN    = 1,
  localparam int TW         = $clog2(NUM_TRACKS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          UART_RXD,
  output logic          UART_TXD,
  input  logic [TW-1:0] CUR_TRACK,
  output logic          CMD_VALID,
  output logic [TW-1:0] PREV_STEPS,
  output logic [TW-1:0] NEXT_STEPS,
  output logic          VOL_UP,
  output logic          VOL_DOWN,
  output logic [7:0]    RXD_DATA,
  output logic          FRAME_ERR,
  output logic          CMD_ERR
);
  import bt_pkg::*;

  localparam int            DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [7:0]    SEL_LAST = 8'(CMD_SEL_BASE + NUM_TRACKS - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    rxd_meta;
  logic          rx_valid;

  // Free-running baud divider shared by RX and TX
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) div_cnt <= '0;
    else      div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end
  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rxd_meta <= 2'b11;
    else      rxd_meta <= {rxd_meta[0], UART_RXD};
  end

  uart_rx_core #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
    .CLK       (CLK),
    .RST       (RST),
    .tick      (tick),
    .rxd_sync  (rxd_meta[1]),
    .rx_valid  (rx_valid),
    .rx_data   (RXD_DATA),
    .frame_err (FRAME_ERR)
  );

  logic [TW-1:0] sel_t;
  logic          dec_legal, dec_vup, dec_vdn;
  logic [TW-1:0] dec_prev, dec_next;

  assign sel_t = TW'(RXD_DATA - CMD_SEL_BASE);

  // Opcode decode of the byte currently held in RXD_DATA
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    dec_legal = 1'b0;
    dec_vup   = 1'b0;
    dec_vdn   = 1'b0;
    dec_prev  = '0;
    dec_next  = '0;
    if (RXD_DATA == CMD_PREV) begin
      dec_legal = 1'b1;
      dec_prev  = TW'(1);
    end else if (RXD_DATA == CMD_NEXT) begin
      dec_legal = 1'b1;
      dec_next  = TW'(1);
    end else if (RXD_DATA == CMD_VUP) begin
      dec_legal = 1'b1;
      dec_vup   = 1'b1;
    end else if (RXD_DATA == CMD_VDN) begin
      dec_legal = 1'b1;
      dec_vdn   = 1'b1;
    end else if (RXD_DATA >= CMD_SEL_BASE && RXD_DATA <= SEL_LAST) begin
      dec_legal = 1'b1;
      if (sel_t < CUR_TRACK)      dec_prev = CUR_TRACK - sel_t;
      else if (sel_t > CUR_TRACK) dec_next = sel_t - CUR_TRACK;
    end
  end

  // Registered command outputs, one cycle after rx_valid
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CMD_VALID  <= 1'b0;
      CMD_ERR    <= 1'b0;
      VOL_UP     <= 1'b0;
      VOL_DOWN   <= 1'b0;
      PREV_STEPS <= '0;
      NEXT_STEPS <= '0;
    end else begin
      CMD_VALID  <= rx_valid & dec_legal;
      CMD_ERR    <= rx_valid & ~dec_legal;
      VOL_UP     <= rx_valid & dec_vup;
      VOL_DOWN   <= rx_valid & dec_vdn;
      PREV_STEPS <= rx_valid ? dec_prev : '0;
      NEXT_STEPS <= rx_valid ? dec_next : '0;
    end
  end

  logic       pend_valid;
  logic [7:0] pend_data;
  logic [1:0] tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  logic       txd_q;
  logic       tx_load;
  logic       ack_push;

  assign ack_push = (ECHO_EN != 0) && (rx_valid || FRAME_ERR);
  assign tx_load  = (tx_state == ST_IDLE) && tick && pend_valid;

  // One-deep pending ack; a newer ack replaces one not yet taken by TX
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      if (tx_load) pend_valid <= 1'b0;
      if (ack_push) begin
        pend_valid <= 1'b1;
        pend_data  <= (rx_valid && dec_legal) ? RXD_DATA : ACK_ERR;
      end
    end
  end

  // 8N1 transmitter; each bit lasts OVERSAMPLE ticks
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else if (tx_state == ST_IDLE) begin
      if (tx_load) begin
        tx_shift <= pend_data;
        tx_cnt   <= '0;
        txd_q    <= 1'b0;
        tx_state <= ST_START;
      end
    end else if (tick) begin
      if (tx_cnt != BIT_LAST) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          ST_START: begin
            txd_q    <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_state <= ST_DATA;
          end
          ST_DATA: begin
            if (tx_bit == 3'd7) begin
              txd_q    <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              txd_q    <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign UART_TXD = (ECHO_EN != 0) ? txd_q : 1'b1;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Directed bench for bt_cmd_decoder, run at a fast baud (4 clocks per tick,
// 64 clocks per bit) so every scenario fits in a short simulation.
module tb_bt_cmd_decoder;

  localparam int TW      = 3;
  localparam int BIT_CLK = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          UART_RXD;
  logic          UART_TXD;
  logic [TW-1:0] CUR_TRACK;
  logic          CMD_VALID;
  logic [TW-1:0] PREV_STEPS;
  logic [TW-1:0] NEXT_STEPS;
  logic          VOL_UP;
  logic          VOL_DOWN;
  logic [7:0]    RXD_DATA;
  logic          FRAME_ERR;
  logic          CMD_ERR;

  bt_cmd_decoder #(
    .CLK_HZ(100_000_000), .BAUD(1_562_500), .OVERSAMPLE(16),
    .NUM_TRACKS(8), .ECHO_EN(1)
  ) dut (
    .CLK(CLK), .RST(RST), .UART_RXD(UART_RXD), .UART_TXD(UART_TXD),
    .CUR_TRACK(CUR_TRACK), .CMD_VALID(CMD_VALID), .PREV_STEPS(PREV_STEPS),
    .NEXT_STEPS(NEXT_STEPS), .VOL_UP(VOL_UP), .VOL_DOWN(VOL_DOWN),
    .RXD_DATA(RXD_DATA), .FRAME_ERR(FRAME_ERR), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [TW-1:0] prev;
    logic [TW-1:0] next;
    logic          vu;
    logic          vd;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] tx_q[$];
  int         cmd_err_cnt = 0;
  int         frame_err_cnt = 0;
  int         stray_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         c0, t0, e0, f0;

  // Record every decoded pulse and any step/volume output outside CMD_VALID
  always @(negedge CLK) begin
    if (CMD_VALID) cmd_q.push_back('{PREV_STEPS, NEXT_STEPS, VOL_UP, VOL_DOWN});
    if (CMD_ERR)   cmd_err_cnt++;
    if (FRAME_ERR) frame_err_cnt++;
    if (!CMD_VALID && (PREV_STEPS != 0 || NEXT_STEPS != 0 || VOL_UP || VOL_DOWN)) stray_cnt++;
    if (PREV_STEPS != 0 && NEXT_STEPS != 0) stray_cnt++;
    if (VOL_UP && VOL_DOWN) stray_cnt++;
  end

  // Decode UART_TXD frames into tx_q
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge UART_TXD);
      repeat (BIT_CLK / 2) @(posedge CLK);
      #1;
      if (UART_TXD == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLK) @(posedge CLK);
          #1;
          b[i] = UART_TXD;
        end
        repeat (BIT_CLK) @(posedge CLK);
        tx_q.push_back(b);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic snapshot();
    c0 = cmd_q.size();
    t0 = tx_q.size();
    e0 = cmd_err_cnt;
    f0 = frame_err_cnt;
  endtask

  // Bounded wait for n captured TX bytes
  task automatic wait_tx(input int n);
    for (int i = 0; i < 3000 && tx_q.size() < n; i++) @(posedge CLK);
    #1;
  endtask

  // Full 8N1 frame; a low stop bit is held briefly then the line idles
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    UART_RXD = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      wait_clks(BIT_CLK);
    end
    UART_RXD = stop_bit;
    if (stop_bit) begin
      wait_clks(BIT_CLK);
    end else begin
      wait_clks(48);
      UART_RXD = 1'b1;
      wait_clks(2 * BIT_CLK);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] b,
                         input int prev, input int next, input logic vu, input logic vd);
    snapshot();
    send_byte(b, 1'b1);
    wait_clks(4);
    check({tag, "_ncmd"}, cmd_q.size() - c0, 1);
    check({tag, "_prev"}, cmd_q[c0].prev, prev);
    check({tag, "_next"}, cmd_q[c0].next, next);
    check({tag, "_vol"}, {cmd_q[c0].vu, cmd_q[c0].vd}, {vu, vd});
    check({tag, "_cmd_err"}, cmd_err_cnt - e0, 0);
    check({tag, "_rxd_data"}, RXD_DATA, b);
    wait_tx(t0 + 1);
    check({tag, "_ack"}, tx_q[t0], b);
  endtask

  task automatic run_err(input string tag, input logic [7:0] b, input logic stop_bit);
    logic [7:0] old_data;
    old_data = RXD_DATA;
    snapshot();
    send_byte(b, stop_bit);
    wait_clks(4);
    check({tag, "_ncmd"}, cmd_q.size() - c0, 0);
    check({tag, "_cmd_err"}, cmd_err_cnt - e0, stop_bit ? 1 : 0);
    check({tag, "_frame_err"}, frame_err_cnt - f0, stop_bit ? 0 : 1);
    check({tag, "_rxd_data"}, RXD_DATA, stop_bit ? b : old_data);
    wait_tx(t0 + 1);
    check({tag, "_ack"}, tx_q[t0], 8'hFF);
  endtask

  initial begin
    UART_RXD  = 1'b1;
    CUR_TRACK = '0;
    RST       = 1'b0;
    wait_clks(5);
    check("rst_txd", UART_TXD, 1);
    check("rst_pulses", {CMD_VALID, CMD_ERR, FRAME_ERR, VOL_UP, VOL_DOWN}, 0);
    check("rst_steps", {PREV_STEPS, NEXT_STEPS}, 0);
    check("rst_rxd_data", RXD_DATA, 0);
    RST = 1'b1;
    wait_clks(20);

    // Single-step and absolute selects, including both ends of the track range
    run_cmd("next", 8'h02, 0, 1, 1'b0, 1'b0);
    CUR_TRACK = 3'd6;
    run_cmd("sel_back", 8'h06, 5, 0, 1'b0, 1'b0);
    CUR_TRACK = 3'd1;
    run_cmd("sel_fwd", 8'h0C, 0, 6, 1'b0, 1'b0);
    CUR_TRACK = 3'd3;
    run_cmd("sel_same", 8'h08, 0, 0, 1'b0, 1'b0);
    CUR_TRACK = 3'd7;
    run_cmd("sel_t0", 8'h05, 7, 0, 1'b0, 1'b0);

    // Undefined opcodes just past and below the legal range, then a bad stop bit
    run_err("bad_0d", 8'h0D, 1'b1);
    run_err("bad_00", 8'h00, 1'b1);
    run_err("frame", 8'h03, 1'b0);

    // Short low glitch on an idle line
    snapshot();
    UART_RXD = 1'b0;
    wait_clks(12);
    UART_RXD = 1'b1;
    wait_clks(1500);
    check("glitch_ncmd", cmd_q.size() - c0, 0);
    check("glitch_errs", (cmd_err_cnt - e0) + (frame_err_cnt - f0), 0);
    check("glitch_tx", tx_q.size() - t0, 0);

    // Back-to-back frames with no idle gap
    snapshot();
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_clks(4);
    check("b2b_ncmd", cmd_q.size() - c0, 3);
    check("b2b_vup", {cmd_q[c0].vu, cmd_q[c0].vd}, 2'b10);
    check("b2b_vdn", {cmd_q[c0 + 1].vu, cmd_q[c0 + 1].vd}, 2'b01);
    check("b2b_prev", cmd_q[c0 + 2].prev, 1);
    wait_tx(t0 + 2);
    wait_clks(1400);
    check("b2b_ack_first", tx_q[t0], 8'h03);
    check("b2b_ack_last", tx_q[tx_q.size() - 1], 8'h01);

    // Reset in the middle of a frame's data bits
    snapshot();
    UART_RXD = 1'b0;
    wait_clks(BIT_CLK);
    UART_RXD = 1'b0;
    wait_clks(BIT_CLK);
    UART_RXD = 1'b1;
    wait_clks(BIT_CLK);
    UART_RXD = 1'b0;
    wait_clks(BIT_CLK / 2);
    RST = 1'b0;
    wait_clks(2);
    check("mid_rst_txd", UART_TXD, 1);
    check("mid_rst_rxd_data", RXD_DATA, 0);
    UART_RXD = 1'b1;
    wait_clks(10);
    RST = 1'b1;
    wait_clks(1500);
    check("mid_rst_ncmd", cmd_q.size() - c0, 0);
    check("mid_rst_errs", (cmd_err_cnt - e0) + (frame_err_cnt - f0), 0);
    check("mid_rst_tx", tx_q.size() - t0, 0);
    run_cmd("after_rst", 8'h01, 1, 0, 1'b0, 1'b0);

    check("stray_outputs", stray_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
